rf_text_cell_fetch: RTL and testbench

RF_TEXT_CELL_FETCH -- requirements
Module: rf_text_cell_fetch

---
 rtl/rf_text_pkg.sv | 19 +
 rtl/rf_text_cell_fifo.sv | 63 ++++++
 rtl/rf_text_cell_fetch.sv | 149 ++++++++++++++
 tb/tb_rf_text_cell_fetch.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_text_pkg.sv
// Shared types and address helper for the text-mode cell fetcher.
package rf_text_pkg;

    localparam int unsigned CELL_WID = 64;

    typedef logic [CELL_WID-1:0] cell_t;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        WAIT
    } state_t;

    // Single conditional subtract: callers never pass more than 2*count-1.
    function automatic logic [31:0] wrap(input logic [31:0] x, input logic [31:0] count);
        return (x >= count) ? (x - count) : x;
    endfunction

endpackage

// File: rtl/rf_text_cell_fifo.sv
// Synchronous first-word-fall-through FIFO with flush and occupancy output.
module rf_text_cell_fifo #(
    parameter int unsigned W     = 65,
    parameter int unsigned DEPTH = 8
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_flush,
    input  logic                       i_push,
    input  logic [W-1:0]               i_data,
    input  logic                       i_pop,
    output logic [W-1:0]               o_data,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_wr_ptr;
    logic [PW:0]   r_count;
    logic          w_push;
    logic          w_pop;

    assign w_pop  = i_pop && (r_count != '0);
    assign w_push = i_push && ((32'(r_count) != DEPTH) || w_pop);

    always_ff @(posedge i_clk) begin
        if (w_push && !i_flush) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_empty = (r_count == '0);
    assign o_count = r_count;

endmodule

// File: rtl/rf_text_cell_fetch.sv
// Text-mode cell fetcher: walks screen RAM one text row per scanline window
// and streams cells (with end-of-line flag) to the character renderer.
module rf_text_cell_fetch
    import rf_text_pkg::*;
#(
    parameter int unsigned WID             = 64,
    parameter int unsigned TEXT_CELL_COUNT = 49152,
    parameter int unsigned FIFO_DEPTH      = 8,
    parameter int unsigned AWID            = $clog2(TEXT_CELL_COUNT)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            frame_start_i,
    input  logic            line_start_i,
    input  logic [AWID-1:0] start_addr_i,
    input  logic [7:0]      cols_i,
    input  logic [5:0]      char_height_i,
    output logic            csb_o,
    output logic [AWID-1:0] adrb_o,
    input  logic [WID-1:0]  datb_i,
    output logic [WID-1:0]  cell_o,
    output logic            cell_valid_o,
    input  logic            cell_ready_i,
    output logic            eol_o,
    output logic [5:0]      scan_o,
    output logic            late_o
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [AWID-1:0] r_row_base;
    logic [AWID-1:0] r_line_base;
    logic [7:0]      r_col;
    logic [7:0]      r_cols;
    logic [5:0]      r_scan;
    logic [5:0]      r_line_scan;
    logic            r_inflight;
    logic            r_inflight_eol;
    logic            r_late;

    logic            w_issue;
    logic            w_last;
    logic            w_room;
    logic            w_abort;
    logic [AWID-1:0] w_eff_base;
    logic [5:0]      w_eff_scan;
    logic [AWID-1:0] w_next_row;
    logic [AWID-1:0] w_rd_addr;
    logic [CW-1:0]   w_fifo_count;
    logic            w_fifo_empty;
    logic [WID:0]    w_fifo_head;

    // A frame start coincident with a line start takes effect for that line.
    assign w_eff_base = frame_start_i ? start_addr_i : r_row_base;
    assign w_eff_scan = frame_start_i ? '0 : r_scan;
    assign w_next_row = AWID'(wrap(32'(w_eff_base) + 32'(cols_i), TEXT_CELL_COUNT));
    assign w_rd_addr  = AWID'(wrap(32'(r_line_base) + 32'(r_col), TEXT_CELL_COUNT));
    assign w_last     = (r_col == r_cols - 8'd1);
    assign w_room     = (32'(w_fifo_count) + 32'(r_inflight)) < FIFO_DEPTH;
    assign w_abort    = line_start_i && (r_state != IDLE);

    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        case (r_state)
            FETCH: begin
                w_issue = !line_start_i && w_room;
                if (w_issue && w_last) begin
                    w_state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (r_inflight) begin
                    w_state_nxt = IDLE;
                end
            end
            default: ;
        endcase
        if (line_start_i) begin
            w_state_nxt = (cols_i != '0) ? FETCH : IDLE;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state        <= IDLE;
            r_row_base     <= '0;
            r_line_base    <= '0;
            r_col          <= '0;
            r_cols         <= '0;
            r_scan         <= '0;
            r_line_scan    <= '0;
            r_inflight     <= 1'b0;
            r_inflight_eol <= 1'b0;
            r_late         <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_inflight     <= w_issue;
            r_inflight_eol <= w_issue && w_last;
            r_late         <= w_abort;
            if (w_issue) begin
                r_col <= r_col + 8'd1;
            end
            if (line_start_i) begin
                r_line_base <= w_eff_base;
                r_line_scan <= w_eff_scan;
                r_col       <= '0;
                r_cols      <= cols_i;
                if (w_eff_scan == char_height_i) begin
                    r_scan     <= '0;
                    r_row_base <= w_next_row;
                end else begin
                    r_scan     <= w_eff_scan + 6'd1;
                    r_row_base <= w_eff_base;
                end
            end else if (frame_start_i) begin
                r_row_base <= start_addr_i;
                r_scan     <= '0;
            end
        end
    end

    // Abort flush beats the push of a datum returning for the old line.
    rf_text_cell_fifo #(
        .W     (WID + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (clk_i),
        .i_rst   (rst_i),
        .i_flush (w_abort),
        .i_push  (r_inflight),
        .i_data  ({r_inflight_eol, datb_i}),
        .i_pop   (cell_valid_o && cell_ready_i),
        .o_data  (w_fifo_head),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

    assign csb_o        = w_issue;
    assign adrb_o       = w_issue ? w_rd_addr : '0;
    assign cell_valid_o = !w_fifo_empty;
    assign cell_o       = cell_valid_o ? w_fifo_head[WID-1:0] : '0;
    assign eol_o        = cell_valid_o && w_fifo_head[WID];
    assign scan_o       = r_line_scan;
    assign late_o       = r_late;

endmodule

// File: tb/tb_rf_text_cell_fetch.sv
// Self-checking bench for rf_text_cell_fetch: vector table, corner sequences, random frames.
module tb_rf_text_cell_fetch;
    import rf_text_pkg::*;

    localparam int unsigned COUNT = 49152;
    localparam int unsigned AW    = 16;

    logic          clk           = 1'b0;
    logic          rst_i         = 1'b1;
    logic          frame_start_i = 1'b0;
    logic          line_start_i  = 1'b0;
    logic [AW-1:0] start_addr_i  = '0;
    logic [7:0]    cols_i        = '0;
    logic [5:0]    char_height_i = '0;
    logic          csb_o;
    logic [AW-1:0] adrb_o;
    cell_t         datb_i        = '0;
    cell_t         cell_o;
    logic          cell_valid_o;
    logic          cell_ready_i  = 1'b1;
    logic          eol_o;
    logic [5:0]    scan_o;
    logic          late_o;

    int n_vec = 0;
    int n_err = 0;
    int unsigned rd_q[$];
    cell_t       cell_q[$];
    bit          eol_q[$];
    int          late_cnt = 0;

    typedef struct {
        int unsigned sa;
        int unsigned cols;
        int unsigned ch;
        int unsigned nl;
        bit          coinc;
        int unsigned exp_base;
        int unsigned exp_scan;
    } vec_t;

    vec_t vt[7];

    always #5 clk = ~clk;

    rf_text_cell_fetch #(
        .WID             (64),
        .TEXT_CELL_COUNT (COUNT),
        .FIFO_DEPTH      (8)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .frame_start_i (frame_start_i),
        .line_start_i  (line_start_i),
        .start_addr_i  (start_addr_i),
        .cols_i        (cols_i),
        .char_height_i (char_height_i),
        .csb_o         (csb_o),
        .adrb_o        (adrb_o),
        .datb_i        (datb_i),
        .cell_o        (cell_o),
        .cell_valid_o  (cell_valid_o),
        .cell_ready_i  (cell_ready_i),
        .eol_o         (eol_o),
        .scan_o        (scan_o),
        .late_o        (late_o)
    );

    function automatic cell_t mem_val(input int unsigned a);
        return {16'hA5C3, 16'(a), 32'(a * 32'h9E3779B1)};
    endfunction

    // Screen RAM: read data one cycle after the enable.
    always @(posedge clk) begin
        if (csb_o) datb_i <= mem_val(32'(adrb_o));
    end

    always @(negedge clk) begin
        if (!rst_i) begin
            if (csb_o) rd_q.push_back(32'(adrb_o));
            if (cell_valid_o && cell_ready_i) begin
                cell_q.push_back(cell_o);
                eol_q.push_back(eol_o);
            end
            if (late_o) late_cnt++;
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_q();
        rd_q.delete();
        cell_q.delete();
        eol_q.delete();
        late_cnt = 0;
    endtask

    task automatic pulse_frame(input int unsigned sa);
        start_addr_i  = AW'(sa);
        frame_start_i = 1'b1;
        tick();
        frame_start_i = 1'b0;
    endtask

    task automatic pulse_line(input bit fs);
        frame_start_i = fs;
        line_start_i  = 1'b1;
        tick();
        line_start_i  = 1'b0;
        frame_start_i = 1'b0;
    endtask

    task automatic wait_cells(input int unsigned n, input bit rnd);
        for (int k = 0; k < 40 * n + 60 && cell_q.size() < n; k++) begin
            if (rnd) cell_ready_i = ($urandom % 4) != 0;
            tick();
        end
        cell_ready_i = 1'b1;
        repeat (4) tick();
    endtask

    task automatic check_line(input string nm, input int unsigned base, input int unsigned scan,
                              input int unsigned cols);
        chk({nm, "_nrd"}, 64'(rd_q.size()), 64'(cols));
        chk({nm, "_ncell"}, 64'(cell_q.size()), 64'(cols));
        chk({nm, "_scan"}, 64'(scan_o), 64'(scan));
        for (int i = 0; i < rd_q.size() && i < cols; i++)
            chk({nm, "_addr"}, 64'(rd_q[i]), 64'((base + i) % COUNT));
        for (int i = 0; i < cell_q.size() && i < cols; i++) begin
            chk({nm, "_cell"}, cell_q[i], mem_val((base + i) % COUNT));
            chk({nm, "_eol"}, 64'(eol_q[i]), 64'(i == cols - 1));
        end
    endtask

    task automatic run_line(input bit fs, input int unsigned base, input int unsigned scan,
                            input int unsigned cols, input bit rnd);
        clear_q();
        pulse_line(fs);
        if (cols == 0) repeat (20) tick();
        else wait_cells(cols, rnd);
        check_line("line", base, scan, cols);
        chk("line_late", 64'(late_cnt), 64'd0);
    endtask

    // Reference: a line's row index is its count since frame start divided by rows' height.
    task automatic run_frame(input int unsigned sa, input int unsigned cols, input int unsigned ch,
                             input int unsigned nl, input bit coinc, input bit rnd);
        cols_i        = 8'(cols);
        char_height_i = 6'(ch);
        start_addr_i  = AW'(sa);
        if (!coinc) pulse_frame(sa);
        for (int unsigned l = 0; l < nl; l++)
            run_line(coinc && l == 0, (sa + (l / (ch + 1)) * cols) % COUNT, l % (ch + 1), cols, rnd);
    endtask

    initial begin
        vt[0] = '{32'h100, 4, 0, 1, 1'b0, 32'h100, 0};
        vt[1] = '{0, 80, 7, 9, 1'b0, 80, 0};
        vt[2] = '{49150, 4, 0, 1, 1'b1, 49150, 0};
        vt[3] = '{0, 3, 1, 5, 1'b1, 6, 0};
        vt[4] = '{49151, 2, 0, 3, 1'b0, 3, 0};
        vt[5] = '{32'h50, 0, 2, 2, 1'b0, 32'h50, 1};
        vt[6] = '{100, 5, 2, 4, 1'b1, 105, 0};

        #1;
        chk("rst_csb", 64'(csb_o), 64'd0);
        chk("rst_adrb", 64'(adrb_o), 64'd0);
        chk("rst_valid", 64'(cell_valid_o), 64'd0);
        chk("rst_cell", cell_o, 64'd0);
        chk("rst_eol", 64'(eol_o), 64'd0);
        chk("rst_scan", 64'(scan_o), 64'd0);
        chk("rst_late", 64'(late_o), 64'd0);
        repeat (3) tick();
        rst_i = 1'b0;
        tick();

        for (int v = 0; v < 7; v++) begin
            run_frame(vt[v].sa, vt[v].cols, vt[v].ch, vt[v].nl, vt[v].coinc, 1'b0);
            if (vt[v].cols != 0)
                chk("vt_base", 64'(rd_q.size() > 0 ? rd_q[0] : 32'hFFFF_FFFF), 64'(vt[v].exp_base));
            chk("vt_scan", 64'(scan_o), 64'(vt[v].exp_scan));
        end

        // Backpressure: FIFO depth bounds outstanding reads.
        char_height_i = 6'd0;
        pulse_frame(32'h200);
        cols_i       = 8'd20;
        cell_ready_i = 1'b0;
        clear_q();
        pulse_line(1'b0);
        repeat (30) tick();
        chk("bp_nrd8", 64'(rd_q.size()), 64'd8);
        chk("bp_csb_low", 64'(csb_o), 64'd0);
        chk("bp_ncell0", 64'(cell_q.size()), 64'd0);
        chk("bp_valid", 64'(cell_valid_o), 64'd1);
        cell_ready_i = 1'b1;
        wait_cells(20, 1'b0);
        check_line("bp", 32'h200, 0, 20);

        // Abort at col 5 with the renderer stalled.
        pulse_frame(32'h300);
        cols_i       = 8'd40;
        cell_ready_i = 1'b0;
        clear_q();
        pulse_line(1'b0);
        for (int k = 0; k < 50 && rd_q.size() < 5; k++) tick();
        chk("ab_col5", 64'(rd_q.size()), 64'd5);
        clear_q();
        pulse_line(1'b0);
        @(negedge clk);
        chk("ab_late_hi", 64'(late_o), 64'd1);
        chk("ab_flushed", 64'(cell_valid_o), 64'd0);
        chk("ab_csb", 64'(csb_o), 64'd1);
        chk("ab_adr", 64'(adrb_o), 64'h328);
        tick();
        @(negedge clk);
        chk("ab_late_lo", 64'(late_o), 64'd0);
        tick();
        cell_ready_i = 1'b1;
        wait_cells(40, 1'b0);
        check_line("ab", 32'h328, 0, 40);
        chk("ab_late_cnt", 64'(late_cnt), 64'd1);

        // Reset in the middle of a line.
        char_height_i = 6'd3;
        pulse_frame(32'h400);
        cols_i = 8'd0;
        pulse_line(1'b0);
        cols_i       = 8'd10;
        cell_ready_i = 1'b0;
        clear_q();
        pulse_line(1'b0);
        for (int k = 0; k < 50 && rd_q.size() < 3; k++) tick();
        chk("rm_scan1", 64'(scan_o), 64'd1);
        #2 rst_i = 1'b1;
        #1;
        chk("rm_csb", 64'(csb_o), 64'd0);
        chk("rm_adrb", 64'(adrb_o), 64'd0);
        chk("rm_valid", 64'(cell_valid_o), 64'd0);
        chk("rm_cell", cell_o, 64'd0);
        chk("rm_eol", 64'(eol_o), 64'd0);
        chk("rm_scan", 64'(scan_o), 64'd0);
        chk("rm_late", 64'(late_o), 64'd0);
        repeat (2) tick();
        clear_q();
        rst_i        = 1'b0;
        cell_ready_i = 1'b1;
        repeat (20) tick();
        chk("rm_nrd", 64'(rd_q.size()), 64'd0);
        chk("rm_ncell", 64'(cell_q.size()), 64'd0);
        chk("rm_valid_after", 64'(cell_valid_o), 64'd0);
        run_frame(32'h20, 3, 0, 1, 1'b0, 1'b0);

        // Random frames with a randomly stalling renderer.
        for (int f = 0; f < 8; f++)
            run_frame($urandom_range(0, COUNT - 1), $urandom_range(0, 24), $urandom_range(0, 3),
                      $urandom_range(2, 6), 1'($urandom % 2), 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
